polar_to_iq_26bit: RTL and testbench

Converts a 26-bit magnitude and a 16-bit phase into signed 26-bit I/Q samples using an iterative rotation-mode CORDIC. It is the inverse companion of the I/Q magnitude estimator in the common library. It sits in the synthesis and regeneration paths, where an envelope and a phase word must be turned back into a complex baseband sample. Input and output use a valid/ready handshake, and one conversion is in flight at a time.

---
 rtl/polar_to_iq_pkg.sv | 59 +++++
 rtl/kinv_scale_26bit.sv | 24 ++
 rtl/polar_to_iq_26bit.sv | 172 +++++++++++++++++
 tb/tb_polar_to_iq_26bit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/polar_to_iq_pkg.sv
// Shared constants and helpers for the polar-to-I/Q CORDIC converter.
//   ITER / GUARD    : micro-rotation count and x/y headroom bits
//   DataW / PhaseW  : magnitude/I/Q width and phase word width
//   KINV            : shift list whose sum of right shifts gives 311/512
//   atan_lut()      : atan(2^-i) in phase LSBs (pi/32768)
//   sat_out()       : symmetric saturation of the internal x/y to the output width
package polar_to_iq_pkg;

  localparam int unsigned ITER    = 16;
  localparam int unsigned GUARD   = 2;
  localparam int unsigned DataW   = 26;
  localparam int unsigned PhaseW  = 16;
  localparam int unsigned IntW    = DataW + GUARD;
  // One extra bit on z so accumulating +/-ATAN[i] never wraps.
  localparam int unsigned ZW      = PhaseW + 1;
  localparam int unsigned CntW    = $clog2(ITER);
  localparam int unsigned KinvN   = 6;
  localparam int unsigned KINV [KinvN] = '{1, 4, 5, 7, 8, 9};
  localparam int unsigned OutMax  = (1 << (DataW - 1)) - 1;

  typedef enum logic [1:0] {StIdle, StPre, StIter, StOut} state_e;

  function automatic logic signed [ZW-1:0] atan_lut(input logic [CntW-1:0] idx);
    case (idx)
      4'd0:    return 17'sd8192;
      4'd1:    return 17'sd4836;
      4'd2:    return 17'sd2555;
      4'd3:    return 17'sd1297;
      4'd4:    return 17'sd651;
      4'd5:    return 17'sd326;
      4'd6:    return 17'sd163;
      4'd7:    return 17'sd81;
      4'd8:    return 17'sd41;
      4'd9:    return 17'sd20;
      4'd10:   return 17'sd10;
      4'd11:   return 17'sd5;
      4'd12:   return 17'sd3;
      4'd13:   return 17'sd1;
      4'd14:   return 17'sd1;
      default: return 17'sd0;
    endcase
  endfunction

  // Clip to [-(2^25-1), 2^25-1]; the range is symmetric so -2^25 never appears.
  function automatic logic signed [DataW-1:0] sat_out(input logic signed [IntW-1:0] v);
    logic signed [IntW-1:0] lim;
    logic signed [IntW-1:0] res;
    lim = IntW'(OutMax);
    if (v > lim) begin
      res = lim;
    end else if (v < -lim) begin
      res = -lim;
    end else begin
      res = v;
    end
    return res[DataW-1:0];
  endfunction

endpackage

// File: rtl/kinv_scale_26bit.sv
// Combinational magnitude pre-scaler: clamps the magnitude to 2^25-1 when bit 25 is set,
// then multiplies by 311/512 as a sum of truncated right shifts.
//   mag_i    : unsigned input magnitude
//   scaled_o : clamped magnitude * 311/512 (always < 2^25)
module kinv_scale_26bit
  import polar_to_iq_pkg::*;
(
  input  logic [DataW-1:0] mag_i,
  output logic [DataW-1:0] scaled_o
);

  logic [DataW-1:0] clamped;
  logic [DataW-1:0] acc;

  always_comb begin
    clamped = mag_i[DataW-1] ? {1'b0, {(DataW - 1){1'b1}}} : mag_i;
    acc     = '0;
    for (int k = 0; k < int'(KinvN); k++) begin
      acc = acc + (clamped >> KINV[k]);
    end
    scaled_o = acc;
  end

endmodule

// File: rtl/polar_to_iq_26bit.sv
// Iterative rotation-mode CORDIC: converts a 26-bit magnitude and 16-bit phase into
// saturated signed 26-bit I/Q. One conversion in flight; 19 cycles per sample.
//   clk, rst_n            : clock, async active-low reset
//   din_valid / din_ready : input handshake (ready is registered, low while busy)
//   din_mag, din_phase    : unsigned magnitude, signed phase (LSB = pi/32768)
//   dout_valid            : one-cycle pulse when dout_I/dout_Q update
//   dout_I, dout_Q        : signed results, held until the next result
module polar_to_iq_26bit
  import polar_to_iq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic [DataW-1:0]        din_mag,
  input  logic [PhaseW-1:0]       din_phase,
  output logic                    dout_valid,
  output logic signed [DataW-1:0] dout_I,
  output logic signed [DataW-1:0] dout_Q
);

  localparam logic [CntW-1:0]   LastIter  = CntW'(ITER - 1);
  localparam logic [PhaseW-1:0] PhaseHalf = {1'b1, {(PhaseW - 1){1'b0}}};

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [DataW-1:0]        mag_q, mag_d;
  logic [PhaseW-1:0]       phase_q, phase_d;
  logic signed [IntW-1:0]  x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]    z_q, z_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic signed [DataW-1:0] i_q, i_d, q_q, q_d;

  logic                    accept;
  logic                    load_in, pre_en, iter_en, out_en;
  logic [DataW-1:0]        m_scaled;
  logic                    fold;
  logic [PhaseW-1:0]       phase_fold;
  logic signed [IntW-1:0]  m_ext, x_sh, y_sh;
  logic signed [ZW-1:0]    atan_i;

  assign accept = din_valid & ready_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StPre;
      StPre:   state_d = StIter;
      StIter:  if (cnt_q == LastIter) state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    load_in = 1'b0;
    pre_en  = 1'b0;
    iter_en = 1'b0;
    out_en  = 1'b0;
    ready_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready_d = ~accept;
        load_in = accept;
      end
      StPre:   pre_en  = 1'b1;
      StIter:  iter_en = 1'b1;
      StOut: begin
        out_en  = 1'b1;
        ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  kinv_scale_26bit u_kinv (
    .mag_i    (mag_q),
    .scaled_o (m_scaled)
  );

  // Datapath next-state
  always_comb begin
    // Phases in (pi/2, 3pi/2) are rotated by pi: negate x0 and move z into [-pi/2, pi/2].
    fold       = phase_q[PhaseW-1] ^ phase_q[PhaseW-2];
    phase_fold = fold ? phase_q + PhaseHalf : phase_q;
    m_ext      = $signed({{GUARD{1'b0}}, m_scaled});
    x_sh       = x_q >>> cnt_q;
    y_sh       = y_q >>> cnt_q;
    atan_i     = atan_lut(cnt_q);

    mag_d   = mag_q;
    phase_d = phase_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    q_d     = q_q;
    valid_d = out_en;

    if (load_in) begin
      mag_d   = din_mag;
      phase_d = din_phase;
    end
    if (pre_en) begin
      x_d   = fold ? -m_ext : m_ext;
      y_d   = '0;
      z_d   = $signed({phase_fold[PhaseW-1], phase_fold});
      cnt_d = '0;
    end
    if (iter_en) begin
      if (!z_q[ZW-1]) begin
        x_d = x_q - y_sh;
        y_d = y_q + x_sh;
        z_d = z_q - atan_i;
      end else begin
        x_d = x_q + y_sh;
        y_d = y_q - x_sh;
        z_d = z_q + atan_i;
      end
      cnt_d = cnt_q + 1'b1;
    end
    if (out_en) begin
      i_d = sat_out(x_q);
      q_d = sat_out(y_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mag_q   <= '0;
      phase_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      i_q     <= '0;
      q_q     <= '0;
    end else begin
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      phase_q <= phase_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      i_q     <= i_d;
      q_q     <= q_d;
    end
  end

  assign din_ready  = ready_q;
  assign dout_valid = valid_q;
  assign dout_I     = i_q;
  assign dout_Q     = q_q;

endmodule

// File: tb/tb_polar_to_iq_26bit.sv
// Self-checking bench for polar_to_iq_26bit: a real-arithmetic polar-to-rectangular model
// with an abstract busy/ready timing model, a per-cycle compare process, and directed
// literal cases that pin the model.
module tb_polar_to_iq_26bit;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               din_valid = 1'b0;
  logic               din_ready;
  logic [25:0]        din_mag = '0;
  logic [15:0]        din_phase = '0;
  logic               dout_valid;
  logic signed [25:0] dout_I;
  logic signed [25:0] dout_Q;

  polar_to_iq_26bit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_mag    (din_mag),
    .din_phase  (din_phase),
    .dout_valid (dout_valid),
    .dout_I     (dout_I),
    .dout_Q     (dout_Q)
  );

  always #5 clk = ~clk;

  localparam real Pi   = 3.14159265358979;
  localparam real FullS = 33554431.0;

  int  n_tests = 0;
  int  n_fail  = 0;
  real tol_scale = 1.0;
  real tol_add   = 8.0;

  // Model state
  bit  m_ready = 1'b0;
  bit  m_busy  = 1'b0;
  bit  m_vpulse = 1'b0;
  int  m_left = 0;
  real m_I = 0.0, m_Q = 0.0, m_tol = 0.0;
  int  m_pulses = 0;
  int  d_pulses = 0;

  task automatic chk_range(input string name, input longint act, input longint lo,
                           input longint hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic chk_near(input string name, input longint act, input real exp,
                          input real tol);
    real d;
    n_tests++;
    d = real'(act) - exp;
    if (d < 0.0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0.1f +/- %0.1f", name, act, exp, tol);
    end
  endtask

  // Behavioural model: ideal mag*cos/sin, clipped; busy for 19 cycles per accepted sample.
  initial begin
    real mc, ang;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_ready = 1'b0;
        m_busy = 1'b0;
        m_vpulse = 1'b0;
        m_left = 0;
      end else begin
        m_vpulse = 1'b0;
        if (m_busy) begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0;
            m_vpulse = 1'b1;
            m_ready = 1'b1;
          end
        end else if (m_ready && din_valid) begin
          mc  = din_mag[25] ? FullS : real'(din_mag);
          ang = real'($signed(din_phase)) * Pi / 32768.0;
          m_I = mc * $cos(ang);
          m_Q = mc * $sin(ang);
          if (m_I > FullS) m_I = FullS;
          if (m_I < -FullS) m_I = -FullS;
          if (m_Q > FullS) m_Q = FullS;
          if (m_Q < -FullS) m_Q = -FullS;
          m_tol = mc * tol_scale / 2048.0 + tol_add;
          m_busy = 1'b1;
          m_left = 18;
          m_ready = 1'b0;
        end else begin
          m_ready = 1'b1;
        end
      end
    end
  end

  // Compare process, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk_range("reset din_ready", longint'(din_ready), 0, 0);
        chk_range("reset dout_valid", longint'(dout_valid), 0, 0);
        chk_range("reset dout_I", longint'(dout_I), 0, 0);
        chk_range("reset dout_Q", longint'(dout_Q), 0, 0);
      end else begin
        chk_range("din_ready", longint'(din_ready), longint'(m_ready), longint'(m_ready));
        chk_range("dout_valid", longint'(dout_valid), longint'(m_vpulse),
                  longint'(m_vpulse));
        if (dout_valid) d_pulses++;
        if (m_vpulse) begin
          m_pulses++;
          if (dout_valid) begin
            chk_near("model dout_I", longint'(dout_I), m_I, m_tol);
            chk_near("model dout_Q", longint'(dout_Q), m_Q, m_tol);
          end
        end
      end
    end
  end

  // Present one sample, wait for acceptance and result; lat = negedges after accept edge.
  task automatic send(input logic [25:0] mag, input logic [15:0] ph, output int lat,
                      output logic signed [25:0] oi, output logic signed [25:0] oq);
    int w;
    w = 0;
    @(negedge clk);
    din_valid = 1'b1;
    din_mag   = mag;
    din_phase = ph;
    while (!din_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    din_valid = 1'b0;
    lat = -1;
    oi  = '0;
    oq  = '0;
    for (int k = 0; k < 40; k++) begin
      if (dout_valid) begin
        lat = k;
        oi  = dout_I;
        oq  = dout_Q;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic directed(input string name, input logic [25:0] mag, input logic [15:0] ph,
                          input longint ilo, input longint ihi, input longint qlo,
                          input longint qhi);
    int lat;
    logic signed [25:0] oi, oq;
    send(mag, ph, lat, oi, oq);
    chk_range({name, " latency"}, longint'(lat), 18, 18);
    chk_range({name, " I"}, longint'(oi), ilo, ihi);
    chk_range({name, " Q"}, longint'(oq), qlo, qhi);
  endtask

  initial begin
    int lat;
    int p0;
    logic signed [25:0] oi, oq;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk_range("ready after reset", longint'(din_ready), 1, 1);

    // Directed cases with literal expectations (mag = 2^20, tolerance 520).
    directed("phase0",   26'd1048576, 16'h0000, 1048056, 1049096, -520, 520);
    directed("phase90",  26'd1048576, 16'h4000, -520, 520, 1048056, 1049096);
    directed("phase45",  26'd1048576, 16'h2000, 740935, 741975, 740935, 741975);
    directed("phase180", 26'd1048576, 16'h8000, -1049096, -1048056, -520, 520);
    directed("phase270", 26'd1048576, 16'hC000, -520, 520, -1049096, -1048056);
    directed("clampsat", 26'h3FFFFFF, 16'h0000, 33554431, 33554431, -16384, 16384);

    // Random samples; the tight bound is pinned by the directed cases above.
    tol_scale = 2.0;
    tol_add   = 32.0;
    for (int n = 0; n < 15; n++) begin
      send(26'($urandom), 16'($urandom), lat, oi, oq);
      chk_range("random latency", longint'(lat), 18, 18);
    end

    // Valid held high with data changing every cycle: five accepts in 95 cycles.
    p0 = d_pulses;
    for (int c = 0; c < 95; c++) begin
      @(negedge clk);
      din_valid = 1'b1;
      din_mag   = 26'($urandom);
      din_phase = 16'($urandom);
    end
    @(negedge clk);
    din_valid = 1'b0;
    repeat (25) @(negedge clk);
    chk_range("streaming pulse count", longint'(d_pulses - p0), 5, 5);

    // Reset during iteration 8 of an in-flight conversion.
    tol_scale = 1.0;
    tol_add   = 8.0;
    directed("pre-reset", 26'd1048576, 16'h2000, 740935, 741975, 740935, 741975);
    @(negedge clk);
    din_valid = 1'b1;
    din_mag   = 26'd2000000;
    din_phase = 16'h1234;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_range("async clear dout_I", longint'(dout_I), 0, 0);
    chk_range("async clear dout_Q", longint'(dout_Q), 0, 0);
    chk_range("async clear dout_valid", longint'(dout_valid), 0, 0);
    chk_range("async clear din_ready", longint'(din_ready), 0, 0);
    p0 = d_pulses;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk_range("ready after mid reset", longint'(din_ready), 1, 1);
    repeat (20) @(negedge clk);
    chk_range("no pulse for discarded", longint'(d_pulses - p0), 0, 0);
    directed("post-reset", 26'd1048576, 16'h0000, 1048056, 1049096, -520, 520);

    repeat (5) @(negedge clk);
    chk_range("total pulses vs model", longint'(d_pulses), longint'(m_pulses),
              longint'(m_pulses));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
